// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter, start + DATA_BITS LSB-first + optional parity + 1/2 stop bits.
// Ports: clk/rst (sync, active-high); tx_valid/tx_data/tx_ready byte handshake;
// baud_tick bit-period pulse from the external counter; baud_start/baud_finish toggle that
// counter on/off around each frame; tx serial line (idle high); busy while a frame is in
// flight; tx_done one-cycle pulse at frame end.
module uart_tx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    input  logic                 baud_tick,
    output logic                 baud_start,
    output logic                 baud_finish,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);
    localparam int IW = $clog2(DATA_BITS) + 1;
    localparam int SB = (STOP_BITS == 2) ? 2 : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 baud_start_q, baud_start_d;
    logic                 baud_finish_q, baud_finish_d;
    logic                 tx_done_q, tx_done_d;
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_idx_d     = bit_idx_q;
        stop_cnt_d    = stop_cnt_q;
        parity_d      = parity_q;
        tx_d          = tx_q;
        busy_d        = busy_q;
        baud_start_d  = 1'b0;
        baud_finish_d = 1'b0;
        tx_done_d     = 1'b0;
        case (state_q)
            IDLE: if (tx_valid) begin
                state_d      = START;
                shreg_d      = tx_data;
                parity_d     = (^tx_data) ^ (PARITY_ODD != 0);
                tx_d         = 1'b0;
                busy_d       = 1'b1;
                baud_start_d = 1'b1;
            end
            // a tick during the baud_start cycle predates the counter and is not a bit boundary
            START: if (baud_tick && !baud_start_q) begin
                state_d   = DATA;
                tx_d      = shreg_q[0];
                shreg_d   = shreg_q >> 1;
                bit_idx_d = '0;
            end
            DATA: if (baud_tick) begin
                if (bit_idx_q == IW'(DATA_BITS - 1)) begin
                    state_d    = (PARITY_EN != 0) ? PARITY : STOP;
                    tx_d       = (PARITY_EN != 0) ? parity_q : 1'b1;
                    stop_cnt_d = 1'b0;
                end else begin
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            PARITY: if (baud_tick) begin
                state_d    = STOP;
                tx_d       = 1'b1;
                stop_cnt_d = 1'b0;
            end
            STOP: if (baud_tick) begin
                if (stop_cnt_q == 1'(SB - 1)) begin
                    state_d       = IDLE;
                    busy_d        = 1'b0;
                    baud_finish_d = 1'b1;
                    tx_done_d     = 1'b1;
                end else begin
                    stop_cnt_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            bit_idx_q     <= '0;
            stop_cnt_q    <= 1'b0;
            parity_q      <= 1'b0;
            tx_q          <= 1'b1;
            busy_q        <= 1'b0;
            baud_start_q  <= 1'b0;
            baud_finish_q <= 1'b0;
            tx_done_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_idx_q     <= bit_idx_d;
            stop_cnt_q    <= stop_cnt_d;
            parity_q      <= parity_d;
            tx_q          <= tx_d;
            busy_q        <= busy_d;
            baud_start_q  <= baud_start_d;
            baud_finish_q <= baud_finish_d;
            tx_done_q     <= tx_done_d;
        end
    end
    assign tx_ready    = (state_q == IDLE);
    assign baud_start  = baud_start_q;
    assign baud_finish = baud_finish_q;
    assign tx          = tx_q;
    assign busy        = busy_q;
    assign tx_done     = tx_done_q;
endmodule
